aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Sequencer for the iterative, one-round-per-cycle AES datapath inside the encryption/decryption wrapper. It runs key expansion into the round-key RAM, then sequences initial AddRoundKey, the middle rounds and the final round for encryption or decryption. It walks round keys forward or reverse and reports completion to the system-level pass/fail indicator. It owns no data. Every datapath enable and address is a decoded output of its state machine.

## Interface
- NR, 10: number of rounds; legal values 10, 12, 14 (AES-128/192/256).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  block request; accepted only on an edge where ready=1.
- mode  in  1  0 encrypt, 1 decrypt; sampled with an accepted start.
- key_load  in  1  new-key request; accepted only on an edge where ready=1.
- ready  out  1  controller in IDLE, able to accept start/key_load.
- key_valid  out  1  round-key RAM holds a complete schedule.
- kram_we  out  1  round-key RAM write enable.
- kram_addr  out  4  round-key RAM address.
- ksch_en  out  1  advance key-schedule generator one step.
- ld_state  out  1  load input block into state register, with AddRoundKey.
- rnd_en  out  1  execute one round on the state register.
- last_rnd  out  1  final round; datapath bypasses (Inv)MixColumns.
- inv  out  1  registered mode of the current operation.
- round_idx  out  4  current round number, 0..NR.
- done  out  1  one-cycle pulse, result valid in state register.
- key_err  out  1  one-cycle pulse, start accepted with key_valid=0.
- finished  out  1  sticky; set by first done, cleared only by reset.

## Operation
- Moore FSM with states IDLE, KEXP, INIT, ROUND, FINAL, DONE. All outputs decode from registered state, step counter, inv, key_valid and the sticky flags.
- Requester holds start/key_load high until it sees ready=1 on the sampling edge. Requests are ignored while ready=0.
- IDLE: ready=1 and all enables 0.
  - key_load=1 → KEXP with key_valid cleared. key_load wins over a simultaneous start, which is dropped and must be re-presented.
  - start=1 with key_valid=1 → INIT, inv←mode.
  - start=1 with key_valid=0 → key_err pulse next cycle, stay IDLE.
- KEXP: step k=0..NR, one per cycle.
  - kram_we=1, kram_addr=k, round_idx=k.
  - ksch_en=1 for k≥1 (k=0 writes the cipher key).
  - After k=NR: key_valid←1, → IDLE.
- INIT: ld_state=1, round_idx=0, kram_addr = inv ? NR : 0. → ROUND.
- ROUND: r=1..NR−1, rnd_en=1, round_idx=r, kram_addr = inv ? NR−r : r. After r=NR−1 → FINAL.
- FINAL: rnd_en=1, last_rnd=1, round_idx=NR, kram_addr = inv ? 0 : NR. → DONE.
- DONE: done=1, finished←1. → IDLE.
- kram_addr and round_idx are 4-bit and never exceed NR. The step counter saturates and does not wrap.
- The key schedule is retained across operations until the next key_load or reset.

## Timing
- Reset (asynchronous assert, synchronous-release assumption upstream): state IDLE, counter 0, inv 0, key_valid 0, finished 0. All other outputs 0 except ready=1.
- Reset mid-operation aborts immediately. No done is produced for the aborted block.
- Accept edge E0. Then:
  - INIT in cycle 1.
  - ROUND in cycles 2..NR.
  - FINAL in cycle NR+1.
  - done in cycle NR+2.
  - ready high in cycle NR+3.
  - Encrypt and decrypt latency are identical.
- NR=10 block: done at cycle 12, 13 cycles per block. Back-to-back start held high gives accepts every 13 cycles.
- key_load accept → KEXP cycles 1..NR+1, key_valid and ready high in cycle NR+2 (12 for NR=10).
- key_err pulses exactly one cycle (cycle 1). ready stays 1 throughout.

## Structure
- Shared package aes_pkg holds:
  - the state enum;
  - NR_128/NR_192/NR_256 constants;
  - the mode encoding (ENC=0, DEC=1);
  - the 4-bit round/address width.
- One natural sub-module, aes_kaddr_gen: combinational map of (state, counter, inv) → kram_addr. The rest stays in a single FSM + counter.

## Test plan
- Reset held low for 2 cycles with start=1 → ready=1, key_valid=0, finished=0, no enables asserted.
- key_load pulse → kram_we high 11 cycles, kram_addr 0..10, ksch_en low only at addr 0; key_valid=1 in cycle 12.
- Encrypt after key: start, mode=0 → ld_state cycle 1 at addr 0; rnd_en cycles 2..11 at addr 1..10; last_rnd cycle 11 only; done cycle 12; finished stays 1.
- Decrypt: mode=0 then start, mode=1 → kram_addr sequence 10,9,…,0; done cycle 12; inv=1 throughout.
- start with no key → key_err one cycle, no enables; start and key_load simultaneous → KEXP taken, start ignored.
- Reset asserted in cycle 6 of an encrypt → all outputs to reset values same cycle; done never pulses; key_valid=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round controller.
// Round counts, mode encoding and the FSM state set live here.
package aes_pkg;

    localparam int RW = 4;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEXP  = 3'd1,
        S_INIT  = 3'd2,
        S_ROUND = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } aes_state_e;

endpackage

// File: rtl/aes_kaddr_gen.sv
// Round-key RAM address map: forward walk for encrypt and key expansion,
// reverse walk for decrypt.
module aes_kaddr_gen
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic       [RW-1:0] i_cnt,
    input  aes_state_e          i_state,
    input  logic                i_inv,
    output logic       [RW-1:0] o_addr
);

    localparam logic [RW-1:0] NR4 = RW'(NR);

    always_comb begin
        o_addr = '0;
        case (i_state)
            S_KEXP:  o_addr = i_cnt;
            S_INIT:  o_addr = i_inv ? NR4 : '0;
            S_ROUND: o_addr = i_inv ? (NR4 - i_cnt) : i_cnt;
            S_FINAL: o_addr = i_inv ? '0 : NR4;
            default: o_addr = '0;
        endcase
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Moore sequencer for the one-round-per-cycle AES datapath: key expansion,
// initial AddRoundKey, middle rounds and final round.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic          key_load,
    output logic          ready,
    output logic          key_valid,
    output logic          kram_we,
    output logic [RW-1:0] kram_addr,
    output logic          ksch_en,
    output logic          ld_state,
    output logic          rnd_en,
    output logic          last_rnd,
    output logic          inv,
    output logic [RW-1:0] round_idx,
    output logic          done,
    output logic          key_err,
    output logic          finished
);

    localparam logic [RW-1:0] NR4 = RW'(NR);

    aes_state_e    r_state;
    logic [RW-1:0] r_cnt;
    logic          r_inv;
    logic          r_kv;
    logic          r_fin;
    logic          r_kerr;
    logic [RW-1:0] w_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
            r_kv    <= 1'b0;
            r_fin   <= 1'b0;
            r_kerr  <= 1'b0;
        end else begin
            r_kerr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    // key_load has priority; a coincident start is dropped
                    if (key_load) begin
                        r_state <= S_KEXP;
                        r_kv    <= 1'b0;
                    end else if (start && r_kv) begin
                        r_state <= S_INIT;
                        r_inv   <= mode;
                    end else if (start) begin
                        r_kerr <= 1'b1;
                    end
                end
                S_KEXP: begin
                    if (r_cnt >= NR4) begin
                        r_kv    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_INIT: begin
                    r_cnt   <= 4'd1;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (r_cnt >= NR4 - 1'b1) begin
                        r_cnt   <= NR4;
                        r_state <= S_FINAL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FINAL: r_state <= S_DONE;
                S_DONE: begin
                    r_fin   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    aes_kaddr_gen #(.NR(NR)) u_kaddr (
        .i_cnt   (r_cnt),
        .i_state (r_state),
        .i_inv   (r_inv),
        .o_addr  (w_addr)
    );

    always_comb begin
        ready     = 1'b0;
        kram_we   = 1'b0;
        ksch_en   = 1'b0;
        ld_state  = 1'b0;
        rnd_en    = 1'b0;
        last_rnd  = 1'b0;
        done      = 1'b0;
        round_idx = '0;
        case (r_state)
            S_IDLE:  ready = 1'b1;
            S_KEXP: begin
                kram_we   = 1'b1;
                ksch_en   = (r_cnt != '0);
                round_idx = r_cnt;
            end
            S_INIT:  ld_state = 1'b1;
            S_ROUND: begin
                rnd_en    = 1'b1;
                round_idx = r_cnt;
            end
            S_FINAL: begin
                rnd_en    = 1'b1;
                last_rnd  = 1'b1;
                round_idx = NR4;
            end
            S_DONE:  done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign kram_addr = w_addr;
    assign inv       = r_inv;
    assign key_valid = r_kv;
    assign finished  = r_fin;
    assign key_err   = r_kerr;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl (NR=10): key expansion, encrypt,
// decrypt, key error, request priority, back-to-back and abort.
module tb_aes_round_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic       key_load;
    logic       ready;
    logic       key_valid;
    logic       kram_we;
    logic [3:0] kram_addr;
    logic       ksch_en;
    logic       ld_state;
    logic       rnd_en;
    logic       last_rnd;
    logic       inv;
    logic [3:0] round_idx;
    logic       done;
    logic       key_err;
    logic       finished;

    int n_tests = 0;
    int n_fail  = 0;

    aes_round_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .key_load  (key_load),
        .ready     (ready),
        .key_valid (key_valid),
        .kram_we   (kram_we),
        .kram_addr (kram_addr),
        .ksch_en   (ksch_en),
        .ld_state  (ld_state),
        .rnd_en    (rnd_en),
        .last_rnd  (last_rnd),
        .inv       (inv),
        .round_idx (round_idx),
        .done      (done),
        .key_err   (key_err),
        .finished  (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {ready,key_valid,kram_we,ksch_en,ld_state,rnd_en,last_rnd,done,key_err}
    function automatic logic [8:0] flags();
        return {ready, key_valid, kram_we, ksch_en, ld_state,
                rnd_en, last_rnd, done, key_err};
    endfunction

    task automatic test_reset();
        logic [8:0] f;
        reset = 1'b0; start = 1'b1; mode = 1'b0; key_load = 1'b0;
        tick(); tick();
        f = flags();
        n_tests++;
        if (f !== 9'b1_0000_0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want %b", f, 9'b100000000);
        end
        n_tests++;
        if ({finished, inv, kram_addr, round_idx} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got %b want 0",
                     {finished, inv, kram_addr, round_idx});
        end
        start = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_key_err();
        logic [8:0] f;
        start = 1'b1;
        tick();
        start = 1'b0;
        f = flags();
        n_tests++;
        if (f !== 9'b1_0000_0001) begin
            n_fail++;
            $display("FAIL key_err_c1: got %b want %b", f, 9'b100000001);
        end
        tick();
        f = flags();
        n_tests++;
        if (f !== 9'b1_0000_0000) begin
            n_fail++;
            $display("FAIL key_err_c2: got %b want %b", f, 9'b100000000);
        end
    endtask

    task automatic test_key_load();
        logic [8:0] f;
        logic [8:0] ef;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            ef = {4'b0010, 5'b0};
            ef[5] = (c > 1);
            f = flags();
            n_tests++;
            if (f !== ef || kram_addr !== 4'(c - 1) ||
                round_idx !== 4'(c - 1)) begin
                n_fail++;
                $display("FAIL kexp_c%0d: got %b a%0d r%0d want %b a%0d",
                         c, f, kram_addr, round_idx, ef, c - 1);
            end
            tick();
        end
        f = flags();
        n_tests++;
        if (f !== 9'b1_1000_0000) begin
            n_fail++;
            $display("FAIL kexp_c12: got %b want %b", f, 9'b110000000);
        end
    endtask

    task automatic test_encrypt();
        logic [8:0] f;
        logic [8:0] ef;
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            ef = 9'b0_1000_0000;
            if (c == 1) ef[4] = 1'b1;
            if (c >= 2 && c <= 11) ef[3] = 1'b1;
            if (c == 11) ef[2] = 1'b1;
            if (c == 12) ef[1] = 1'b1;
            f = flags();
            n_tests++;
            if (f !== ef || inv !== 1'b0 ||
                (c <= 11 && (kram_addr !== 4'(c - 1) ||
                             round_idx !== 4'(c - 1)))) begin
                n_fail++;
                $display("FAIL enc_c%0d: got %b a%0d r%0d i%b want %b a%0d",
                         c, f, kram_addr, round_idx, inv, ef, c - 1);
            end
            tick();
        end
        n_tests++;
        if ({ready, done, finished} !== 3'b101) begin
            n_fail++;
            $display("FAIL enc_c13: got %b want 101",
                     {ready, done, finished});
        end
    endtask

    task automatic test_decrypt();
        logic [8:0] f;
        logic [8:0] ef;
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        mode = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            ef = 9'b0_1000_0000;
            if (c == 1) ef[4] = 1'b1;
            if (c >= 2 && c <= 11) ef[3] = 1'b1;
            if (c == 11) ef[2] = 1'b1;
            if (c == 12) ef[1] = 1'b1;
            f = flags();
            n_tests++;
            if (f !== ef || inv !== 1'b1 || finished !== 1'b1 ||
                (c <= 11 && kram_addr !== 4'(11 - c))) begin
                n_fail++;
                $display("FAIL dec_c%0d: got %b a%0d i%b want %b a%0d",
                         c, f, kram_addr, inv, ef, 11 - c);
            end
            tick();
        end
        n_tests++;
        if ({ready, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL dec_c13: got %b want 10", {ready, done});
        end
    endtask

    task automatic test_simultaneous();
        logic [8:0] f;
        start = 1'b1; key_load = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0; key_load = 1'b0;
        f = flags();
        n_tests++;
        if (f !== 9'b0_0100_0000 || kram_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL simul_c1: got %b a%0d want %b a0",
                     f, kram_addr, 9'b001000000);
        end
        for (int c = 2; c <= 12; c++) tick();
        f = flags();
        n_tests++;
        if (f !== 9'b1_1000_0000) begin
            n_fail++;
            $display("FAIL simul_c12: got %b want %b", f, 9'b110000000);
        end
    endtask

    task automatic test_back_to_back();
        int ld_seen;
        int dn_seen;
        ld_seen = 0; dn_seen = 0;
        mode = 1'b0; start = 1'b1;
        tick();
        for (int c = 1; c <= 26; c++) begin
            if (c == 25) start = 1'b0;
            if (ld_state) ld_seen = ld_seen * 100 + c;
            if (done) dn_seen = dn_seen * 100 + c;
            tick();
        end
        start = 1'b0;
        n_tests++;
        if (ld_seen !== 114) begin
            n_fail++;
            $display("FAIL b2b_ld: got %0d want 114", ld_seen);
        end
        n_tests++;
        if (dn_seen !== 1225) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d want 1225", dn_seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] f;
        int dn_cnt;
        dn_cnt = 0;
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        n_tests++;
        if (rnd_en !== 1'b1 || round_idx !== 4'd5) begin
            n_fail++;
            $display("FAIL abort_pre: got rnd%b r%0d want rnd1 r5",
                     rnd_en, round_idx);
        end
        reset = 1'b0;
        #1;
        f = flags();
        n_tests++;
        if (f !== 9'b1_0000_0000 || finished !== 1'b0 ||
            kram_addr !== 4'd0 || round_idx !== 4'd0 || inv !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_now: got %b f%b a%0d r%0d want %b",
                     f, finished, kram_addr, round_idx, 9'b100000000);
        end
        tick(); tick();
        reset = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (done) dn_cnt++;
            tick();
        end
        n_tests++;
        if (dn_cnt !== 0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after: got done%0d kv%b want 0 0",
                     dn_cnt, key_valid);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0; key_load = 1'b0;
        test_reset();
        test_key_err();
        test_key_load();
        test_encrypt();
        test_decrypt();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
